// File: rtl/cache_set_assoc_if.sv
// Request/response bundle between the cache controller and one cache_set_assoc set.
// Carries the request handshake, the registered response, the FLUSH pulse, statistics and FSM debug.
interface cache_set_assoc_if #(
  parameter int TAG_WIDTH      = 20,
  parameter int WORD_SEL_WIDTH = 3
);
  // Handshake: a request transfers on any rising edge where req_valid and req_ready are both high.
  // The set answers with a one-cycle rsp_valid strobe and has no response back-pressure.
  logic                      req_valid;
  logic                      req_ready;
  logic [2:0]                req_op;
  logic [TAG_WIDTH-1:0]      req_tag;
  logic [WORD_SEL_WIDTH-1:0] req_word;
  logic [31:0]               req_data;

  logic                      rsp_valid;
  logic                      rsp_hit;
  logic [31:0]               rsp_data;
  logic                      rsp_victim_valid;
  logic                      rsp_victim_dirty;
  logic [TAG_WIDTH-1:0]      rsp_victim_tag;
  logic                      flush_done;

  logic [31:0]               stat_hits;
  logic [31:0]               stat_misses;
  logic                      dbg_state;

  modport master (
    output req_valid, req_op, req_tag, req_word, req_data,
    input  req_ready, rsp_valid, rsp_hit, rsp_data, rsp_victim_valid, rsp_victim_dirty,
    input  rsp_victim_tag, flush_done, stat_hits, stat_misses, dbg_state
  );

  modport slave (
    input  req_valid, req_op, req_tag, req_word, req_data,
    output req_ready, rsp_valid, rsp_hit, rsp_data, rsp_victim_valid, rsp_victim_dirty,
    output rsp_victim_tag, flush_done, stat_hits, stat_misses, dbg_state
  );
endinterface

// File: rtl/cache_set_assoc.sv
// N-way set-associative cache set with LRU/FIFO/LFU replacement and a multi-cycle FLUSH walk.
// Optional READ/WRITE hit/miss counters are built when CACHE_SET_STATS_EN is defined.
module cache_set_assoc #(
  parameter int TAG_WIDTH      = 20,
  parameter int WORD_SEL_WIDTH = 3,
  parameter int WAYS           = 4,
  parameter int POLICY         = 0,
  parameter int LFU_WIDTH      = 8
) (
  input logic              clk,
  input logic              reset,
  cache_set_assoc_if.slave bus
);
  localparam int WORDS = 1 << WORD_SEL_WIDTH;
  localparam int WAY_W = $clog2(WAYS);
  localparam logic [LFU_WIDTH-1:0] LFU_MAX  = '1;
  localparam logic [LFU_WIDTH-1:0] LFU_ONE  = LFU_WIDTH'(1);
  localparam logic [WAY_W-1:0]     LAST_WAY = WAY_W'(WAYS - 1);

  localparam logic [2:0] OP_READ  = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_ALLOC = 3'b010;
  localparam logic [2:0] OP_FILL  = 3'b011;
  localparam logic [2:0] OP_INVAL = 3'b100;
  localparam logic [2:0] OP_FLUSH = 3'b101;

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  state_e               state_q, state_d;
  logic [WAY_W-1:0]     flush_idx_q, flush_idx_d;

  logic [WAYS-1:0]      valid_q, valid_d;
  logic [WAYS-1:0]      dirty_q, dirty_d;
  logic [TAG_WIDTH-1:0] tag_q [WAYS];
  logic [TAG_WIDTH-1:0] tag_d [WAYS];
  logic [31:0]          data_q [WAYS][WORDS];

  logic [WAY_W-1:0]     rank_q [WAYS];
  logic [WAY_W-1:0]     rank_d [WAYS];
  logic [WAY_W-1:0]     fifo_ptr_q, fifo_ptr_d;
  logic [LFU_WIDTH-1:0] lfu_q [WAYS];
  logic [LFU_WIDTH-1:0] lfu_d [WAYS];

  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic                 rsp_vv_q, rsp_vv_d;
  logic                 rsp_vd_q, rsp_vd_d;
  logic [TAG_WIDTH-1:0] rsp_vtag_q, rsp_vtag_d;
  logic                 flush_done_q, flush_done_d;

  logic                 accept;
  logic [WAYS-1:0]      hit_vec;
  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic                 has_inv;
  logic [WAY_W-1:0]     inv_way;
  logic [WAY_W-1:0]     lru_victim;
  logic [WAY_W-1:0]     lfu_victim;
  logic [LFU_WIDTH-1:0] lfu_min;
  logic [WAY_W-1:0]     policy_victim;
  logic [WAY_W-1:0]     alloc_way;

  logic                 data_we;
  logic                 touch_en;
  logic                 insert_en;
  logic [WAY_W-1:0]     upd_way;
  logic                 fifo_adv;

  assign accept  = bus.req_valid && (state_q == S_IDLE);
  assign hit     = |hit_vec;
  assign has_inv = ~&valid_q;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[w] && (tag_q[w] == bus.req_tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    // Walk downwards so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w]) inv_way = WAY_W'(w);
    end
  end

  always_comb begin
    lru_victim = '0;
    lfu_victim = '0;
    lfu_min    = lfu_q[0];
    for (int w = 0; w < WAYS; w++) begin
      if (rank_q[w] == LAST_WAY) lru_victim = WAY_W'(w);
    end
    for (int w = 1; w < WAYS; w++) begin
      if (lfu_q[w] < lfu_min) begin
        lfu_min    = lfu_q[w];
        lfu_victim = WAY_W'(w);
      end
    end
    case (POLICY)
      1:       policy_victim = fifo_ptr_q;
      2:       policy_victim = lfu_victim;
      default: policy_victim = lru_victim;
    endcase
    if (hit)          alloc_way = hit_way;
    else if (has_inv) alloc_way = inv_way;
    else              alloc_way = policy_victim;
  end

  always_comb begin
    state_d      = state_q;
    flush_idx_d  = flush_idx_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    rsp_valid_d  = 1'b0;
    rsp_hit_d    = rsp_hit_q;
    rsp_data_d   = rsp_data_q;
    rsp_vv_d     = rsp_vv_q;
    rsp_vd_d     = rsp_vd_q;
    rsp_vtag_d   = rsp_vtag_q;
    flush_done_d = 1'b0;
    data_we      = 1'b0;
    touch_en     = 1'b0;
    insert_en    = 1'b0;
    upd_way      = hit_way;
    fifo_adv     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && bus.req_op == OP_FLUSH) begin
          state_d     = S_FLUSH;
          flush_idx_d = '0;
        end else if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = hit;
          rsp_data_d  = '0;
          rsp_vv_d    = 1'b0;
          rsp_vd_d    = 1'b0;
          rsp_vtag_d  = '0;
          case (bus.req_op)
            OP_READ: begin
              if (hit) begin
                rsp_data_d = data_q[hit_way][bus.req_word];
                touch_en   = 1'b1;
              end
            end
            OP_WRITE: begin
              if (hit) begin
                data_we          = 1'b1;
                dirty_d[hit_way] = 1'b1;
                touch_en         = 1'b1;
              end
            end
            OP_FILL: begin
              data_we = hit;
            end
            OP_ALLOC: begin
              insert_en          = 1'b1;
              upd_way            = alloc_way;
              valid_d[alloc_way] = 1'b1;
              dirty_d[alloc_way] = 1'b0;
              tag_d[alloc_way]   = bus.req_tag;
              if (!hit) begin
                rsp_vv_d   = valid_q[alloc_way];
                rsp_vd_d   = valid_q[alloc_way] && dirty_q[alloc_way];
                rsp_vtag_d = valid_q[alloc_way] ? tag_q[alloc_way] : '0;
                fifo_adv   = !has_inv;
              end
            end
            OP_INVAL: begin
              if (hit) begin
                valid_d[hit_way] = 1'b0;
                dirty_d[hit_way] = 1'b0;
                rsp_vv_d         = 1'b1;
                rsp_vd_d         = dirty_q[hit_way];
                rsp_vtag_d       = tag_q[hit_way];
              end
            end
            default: ;
          endcase
        end
      end
      S_FLUSH: begin
        if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
          rsp_valid_d          = 1'b1;
          rsp_hit_d            = 1'b0;
          rsp_data_d           = '0;
          rsp_vv_d             = 1'b1;
          rsp_vd_d             = 1'b1;
          rsp_vtag_d           = tag_q[flush_idx_q];
          dirty_d[flush_idx_q] = 1'b0;
        end
        if (flush_idx_q == LAST_WAY) begin
          state_d      = S_IDLE;
          flush_done_d = 1'b1;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Only the state of the selected policy is updated; the others stay at reset and drop out.
  always_comb begin
    rank_d     = rank_q;
    fifo_ptr_d = fifo_ptr_q;
    lfu_d      = lfu_q;
    if (POLICY == 0 && (touch_en || insert_en)) begin
      for (int w = 0; w < WAYS; w++) begin
        if (rank_q[w] < rank_q[upd_way]) rank_d[w] = rank_q[w] + 1'b1;
      end
      rank_d[upd_way] = '0;
    end
    if (POLICY == 1 && fifo_adv) begin
      fifo_ptr_d = fifo_ptr_q + 1'b1;
    end
    if (POLICY == 2) begin
      if (insert_en) begin
        lfu_d[upd_way] = LFU_ONE;
      end else if (touch_en) begin
        if (lfu_q[upd_way] == LFU_MAX) begin
          for (int w = 0; w < WAYS; w++) lfu_d[w] = lfu_q[w] >> 1;
          lfu_d[upd_way] = (LFU_MAX >> 1) + LFU_ONE;
        end else begin
          lfu_d[upd_way] = lfu_q[upd_way] + LFU_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      flush_idx_q  <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      fifo_ptr_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_data_q   <= '0;
      rsp_vv_q     <= 1'b0;
      rsp_vd_q     <= 1'b0;
      rsp_vtag_q   <= '0;
      flush_done_q <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        tag_q[w]  <= '0;
        rank_q[w] <= WAY_W'(w);
        lfu_q[w]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      flush_idx_q  <= flush_idx_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      rank_q       <= rank_d;
      fifo_ptr_q   <= fifo_ptr_d;
      lfu_q        <= lfu_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_data_q   <= rsp_data_d;
      rsp_vv_q     <= rsp_vv_d;
      rsp_vd_q     <= rsp_vd_d;
      rsp_vtag_q   <= rsp_vtag_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Line storage carries no reset; a line is only meaningful while its valid bit is set.
  always_ff @(posedge clk) begin
    if (data_we) data_q[hit_way][bus.req_word] <= bus.req_data;
  end

`ifdef CACHE_SET_STATS_EN
  logic [31:0] stat_hits_q, stat_misses_q;
  logic        stat_req;

  assign stat_req = accept && (bus.req_op == OP_READ || bus.req_op == OP_WRITE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else if (stat_req) begin
      if (hit) stat_hits_q   <= stat_hits_q + 32'd1;
      else     stat_misses_q <= stat_misses_q + 32'd1;
    end
  end

  assign bus.stat_hits   = stat_hits_q;
  assign bus.stat_misses = stat_misses_q;
`else
  assign bus.stat_hits   = '0;
  assign bus.stat_misses = '0;
`endif

  assign bus.req_ready        = (state_q == S_IDLE);
  assign bus.dbg_state        = (state_q == S_FLUSH);
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_hit          = rsp_hit_q;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.rsp_victim_valid = rsp_vv_q;
  assign bus.rsp_victim_dirty = rsp_vd_q;
  assign bus.rsp_victim_tag   = rsp_vtag_q;
  assign bus.flush_done       = flush_done_q;
endmodule
